pll_reconf_sequencer: RTL and testbench

- Sequences a PLL reconfiguration each time the resolution-select stage latches a new video mode; that stage pulses trigger_read one cycle after it reads a mode byte.
- Starts the altpll_reconfig controller, which then streams the scan chain out of the serial config ROM.
- Tracks the controller's busy signal, then waits for the HDMI PLL to relock and stay stable.
- Holds the downstream video pipeline in reset for the whole sequence, and reports completion or timeout.

---
 rtl/pll_reconf_if.sv | 33 +++
 rtl/pll_reconf_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_reconf_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconf_if.sv
// pll_reconf_if
//   Groups the trigger, altpll_reconfig and HDMI PLL status signals, plus the
//   sequencer's outputs, into one bundle.
//   Signal protocol (one place, applies to every signal here):
//     trigger_read   : one-cycle pulse from the resolution-select stage.
//     busy           : level from altpll_reconfig, high while the scan chain streams.
//     pll_locked     : asynchronous level from the HDMI PLL.
//     write_from_rom : one-cycle pulse starting altpll_reconfig.
//     video_reset    : level, high holds the downstream video pipeline.
//     reconf_done    : one-cycle pulse on a successful sequence.
//     error          : sticky level, set on any timeout, cleared on success.
//     state_dbg      : current sequencer state encoding.
//   master : the sequencer side.  slave : the surrounding system side.
interface pll_reconf_if;
  logic       trigger_read;
  logic       busy;
  logic       pll_locked;
  logic       write_from_rom;
  logic       video_reset;
  logic       reconf_done;
  logic       error;
  logic [2:0] state_dbg;

  modport master (
    input  trigger_read, busy, pll_locked,
    output write_from_rom, video_reset, reconf_done, error, state_dbg
  );

  modport slave (
    output trigger_read, busy, pll_locked,
    input  write_from_rom, video_reset, reconf_done, error, state_dbg
  );
endinterface

// File: rtl/pll_reconf_sequencer.sv
// pll_reconf_sequencer
//   Runs one HDMI PLL reconfiguration per new video mode: pulses
//   write_from_rom to altpll_reconfig, follows its busy flag, then waits for
//   the PLL lock to stay high for SETTLE_CYCLES before releasing the video
//   pipeline. Every wait is bounded; a timeout sets a sticky error.
// Ports:
//   clock   : system clock, rising edge.
//   reset_n : asynchronous active-low reset, released synchronously inside.
//   bus     : pll_reconf_if.master (trigger/busy/lock in; start pulse,
//             video_reset, reconf_done, error and state_dbg out).
module pll_reconf_sequencer #(
  parameter int unsigned BUSY_START_TIMEOUT = 16,
  parameter int unsigned BUSY_TIMEOUT       = 4096,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned SETTLE_CYCLES      = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  pll_reconf_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_START        = 3'd1,
    S_WAIT_BUSY_HI = 3'd2,
    S_WAIT_BUSY_LO = 3'd3,
    S_WAIT_LOCK    = 3'd4,
    S_DONE         = 3'd5,
    S_ERROR        = 3'd6
  } state_t;

  localparam logic [15:0] BUSY_START_LIM = 16'(BUSY_START_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LIM       = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM       = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LIM     = 16'(SETTLE_CYCLES - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reset asserts immediately and deasserts two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] settle_q, settle_d;
  logic        pending_q, pending_d;
  logic        video_reset_q, video_reset_d;
  logic        error_q, error_d;
  logic        wfr_q, wfr_d;
  logic [1:0]  lock_sync_q;
  logic        lock_s;

  assign lock_s = lock_sync_q[1];

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      settle_q      <= 16'd0;
      pending_q     <= 1'b0;
      video_reset_q <= 1'b1;
      error_q       <= 1'b0;
      wfr_q         <= 1'b0;
      lock_sync_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      settle_q      <= settle_d;
      pending_q     <= pending_d;
      video_reset_q <= video_reset_d;
      error_q       <= error_d;
      wfr_q         <= wfr_d;
      lock_sync_q   <= {lock_sync_q[0], bus.pll_locked};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = 16'd0;
    settle_d      = 16'd0;
    // Triggers arriving mid-sequence collapse into one pending request.
    pending_d     = pending_q | (bus.trigger_read && (state_q != S_IDLE));
    video_reset_d = video_reset_q;
    error_d       = error_q;
    wfr_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.trigger_read || pending_q) begin
          pending_d     = 1'b0;
          video_reset_d = 1'b1;
          state_d       = S_START;
        end
      end
      S_START: begin
        // Registered so the pulse reaches altpll_reconfig glitch-free.
        wfr_d   = 1'b1;
        state_d = S_WAIT_BUSY_HI;
      end
      S_WAIT_BUSY_HI: begin
        cnt_d = sat_inc(cnt_q);
        if (bus.busy) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_BUSY_LO;
        end else if (cnt_q >= BUSY_START_LIM) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_BUSY_LO: begin
        cnt_d = sat_inc(cnt_q);
        if (!bus.busy) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q >= BUSY_LIM) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_LOCK: begin
        cnt_d    = sat_inc(cnt_q);
        // Any low cycle on the lock restarts the settle window.
        settle_d = lock_s ? sat_inc(settle_q) : 16'd0;
        if (lock_s && (settle_q >= SETTLE_LIM)) begin
          state_d = S_DONE;
        end else if (cnt_q >= LOCK_LIM) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        error_d       = 1'b0;
        video_reset_d = 1'b0;
        state_d       = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Error is visible from the first ERROR cycle.
    if (state_d == S_ERROR) error_d = 1'b1;
  end

  assign bus.write_from_rom = wfr_q;
  assign bus.video_reset    = video_reset_q;
  assign bus.reconf_done    = (state_q == S_DONE);
  assign bus.error          = error_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
module tb_pll_reconf_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] cyc;
  int          n_checks;
  int          n_pass;

  logic [31:0] exp_wfr_q[$];
  logic [31:0] exp_done_q[$];
  logic [31:0] mon_wfr_e;
  logic [31:0] mon_done_e;

  pll_reconf_if bus ();

  pll_reconf_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 32'd0;
  always @(posedge clock) cyc <= cyc + 32'd1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (bus.write_from_rom === 1'b1) begin
      n_checks++;
      if (exp_wfr_q.size() == 0) begin
        $display("FAIL wfr_unexpected: pulse at cycle %0d, required no pulse", cyc);
      end else begin
        mon_wfr_e = exp_wfr_q.pop_front();
        if (cyc !== mon_wfr_e) $display("FAIL wfr_cycle: pulse at cycle %0d, required cycle %0d", cyc, mon_wfr_e);
        else n_pass++;
      end
    end
    if (bus.reconf_done === 1'b1) begin
      n_checks++;
      if (exp_done_q.size() == 0) begin
        $display("FAIL done_unexpected: pulse at cycle %0d, required no pulse", cyc);
      end else begin
        mon_done_e = exp_done_q.pop_front();
        if (cyc !== mon_done_e) $display("FAIL done_cycle: pulse at cycle %0d, required cycle %0d", cyc, mon_done_e);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input logic [31:0] c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_trigger();
    bus.trigger_read = 1'b1;
    tick();
    bus.trigger_read = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n          = 1'b0;
    bus.trigger_read = 1'b0;
    bus.busy         = 1'b0;
    bus.pll_locked   = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL reset_state: got %0d, want 0", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL reset_video_reset: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++; if (bus.write_from_rom !== 1'b0) $display("FAIL reset_wfr: got %b, want 0", bus.write_from_rom); else n_pass++;
    n_checks++; if (bus.reconf_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", bus.reconf_done); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL reset_error: got %b, want 0", bus.error); else n_pass++;
    reset_n = 1'b1;
    run_until(32'd8);
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL reset_vr_held: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL reset_idle: got %0d, want 0", bus.state_dbg); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] t;
    run_until(32'd10);
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    exp_done_q.push_back(t + 32'd1313);
    pulse_trigger();
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL basic_vr_start: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++; if (bus.state_dbg !== 3'd1) $display("FAIL basic_state_start: got %0d, want 1", bus.state_dbg); else n_pass++;
    run_until(t + 32'd2);
    bus.pll_locked = 1'b0;
    n_checks++; if (bus.state_dbg !== 3'd2) $display("FAIL basic_state_bhi: got %0d, want 2", bus.state_dbg); else n_pass++;
    run_until(t + 32'd5);
    bus.busy = 1'b1;
    run_until(t + 32'd1005);
    bus.busy = 1'b0;
    n_checks++; if (bus.state_dbg !== 3'd3) $display("FAIL basic_state_blo: got %0d, want 3", bus.state_dbg); else n_pass++;
    run_until(t + 32'd1006);
    n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL basic_state_lock: got %0d, want 4", bus.state_dbg); else n_pass++;
    run_until(t + 32'd1055);
    bus.pll_locked = 1'b1;
    run_until(t + 32'd1312);
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL basic_vr_before_done: got %b, want 1", bus.video_reset); else n_pass++;
    run_until(t + 32'd1314);
    n_checks++; if (bus.video_reset !== 1'b0) $display("FAIL basic_vr_after: got %b, want 0", bus.video_reset); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL basic_error: got %b, want 0", bus.error); else n_pass++;
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL basic_state_idle: got %0d, want 0", bus.state_dbg); else n_pass++;
    run_until(t + 32'd1330);
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL basic_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] t;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    exp_done_q.push_back(t + 32'd489);
    pulse_trigger();
    run_until(t + 32'd2);   bus.pll_locked = 1'b0;
    run_until(t + 32'd5);   bus.busy = 1'b1;
    run_until(t + 32'd25);  bus.busy = 1'b0;
    run_until(t + 32'd30);  bus.pll_locked = 1'b1;
    run_until(t + 32'd230); bus.pll_locked = 1'b0;
    run_until(t + 32'd231); bus.pll_locked = 1'b1;
    run_until(t + 32'd300);
    n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL glitch_state_mid: got %0d, want 4", bus.state_dbg); else n_pass++;
    run_until(t + 32'd488);
    n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL glitch_state_late: got %0d, want 4", bus.state_dbg); else n_pass++;
    run_until(t + 32'd495);
    n_checks++; if (bus.video_reset !== 1'b0) $display("FAIL glitch_vr_after: got %b, want 0", bus.video_reset); else n_pass++;
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL glitch_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    exp_done_q.push_back(t + 32'd362);
    exp_wfr_q.push_back(t + 32'd365);
    exp_done_q.push_back(t + 32'd635);
    pulse_trigger();
    run_until(t + 32'd5); bus.busy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      run_until(t + 32'(20 * k));
      n_checks++; if (bus.state_dbg !== 3'd3) $display("FAIL b2b_state_blo_%0d: got %0d, want 3", k, bus.state_dbg); else n_pass++;
      pulse_trigger();
    end
    run_until(t + 32'd105); bus.busy = 1'b0;
    run_until(t + 32'd364);
    n_checks++; if (bus.state_dbg !== 3'd1) $display("FAIL b2b_restart: got %0d, want 1", bus.state_dbg); else n_pass++;
    run_until(t + 32'd368); bus.busy = 1'b1;
    run_until(t + 32'd378); bus.busy = 1'b0;
    run_until(t + 32'd680);
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL b2b_final_idle: got %0d, want 0", bus.state_dbg); else n_pass++;
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL b2b_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_done_edge();
    logic [31:0] t;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    exp_done_q.push_back(t + 32'd272);
    exp_wfr_q.push_back(t + 32'd275);
    exp_done_q.push_back(t + 32'd545);
    pulse_trigger();
    run_until(t + 32'd5);  bus.busy = 1'b1;
    run_until(t + 32'd15); bus.busy = 1'b0;
    run_until(t + 32'd272);
    n_checks++; if (bus.state_dbg !== 3'd5) $display("FAIL edge_state_done: got %0d, want 5", bus.state_dbg); else n_pass++;
    pulse_trigger();
    run_until(t + 32'd274);
    n_checks++; if (bus.state_dbg !== 3'd1) $display("FAIL edge_restart: got %0d, want 1", bus.state_dbg); else n_pass++;
    run_until(t + 32'd278); bus.busy = 1'b1;
    run_until(t + 32'd288); bus.busy = 1'b0;
    run_until(t + 32'd560);
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL edge_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_busy_never();
    logic [31:0] t;
    logic [31:0] t2;
    bus.pll_locked = 1'b1;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    pulse_trigger();
    run_until(t + 32'd17);
    n_checks++; if (bus.state_dbg !== 3'd2) $display("FAIL nobusy_state_wait: got %0d, want 2", bus.state_dbg); else n_pass++;
    run_until(t + 32'd18);
    n_checks++; if (bus.state_dbg !== 3'd6) $display("FAIL nobusy_state_error: got %0d, want 6", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL nobusy_error: got %b, want 1", bus.error); else n_pass++;
    run_until(t + 32'd30);
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL nobusy_idle: got %0d, want 0", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL nobusy_vr_held: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL nobusy_error_sticky: got %b, want 1", bus.error); else n_pass++;
    t2 = cyc;
    exp_wfr_q.push_back(t2 + 32'd2);
    exp_done_q.push_back(t2 + 32'd272);
    pulse_trigger();
    run_until(t2 + 32'd5);  bus.busy = 1'b1;
    run_until(t2 + 32'd15); bus.busy = 1'b0;
    run_until(t2 + 32'd273);
    n_checks++; if (bus.error !== 1'b0) $display("FAIL recover_error: got %b, want 0", bus.error); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b0) $display("FAIL recover_vr: got %b, want 0", bus.video_reset); else n_pass++;
    run_until(t2 + 32'd290);
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL nobusy_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] t;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    pulse_trigger();
    run_until(t + 32'd2);  bus.pll_locked = 1'b0;
    run_until(t + 32'd5);  bus.busy = 1'b1;
    run_until(t + 32'd15); bus.busy = 1'b0;
    run_until(t + 32'd50);
    n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL rmid_state_lock: got %0d, want 4", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL rmid_vr_before: got %b, want 1", bus.video_reset); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL rmid_state_async: got %0d, want 0", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL rmid_vr_async: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++; if (bus.write_from_rom !== 1'b0) $display("FAIL rmid_wfr_async: got %b, want 0", bus.write_from_rom); else n_pass++;
    n_checks++; if (bus.reconf_done !== 1'b0) $display("FAIL rmid_done_async: got %b, want 0", bus.reconf_done); else n_pass++;
    repeat (5) tick();
    reset_n        = 1'b1;
    bus.pll_locked = 1'b1;
    run_until(cyc + 32'd40);
    n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL rmid_idle_after: got %0d, want 0", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL rmid_vr_after: got %b, want 1", bus.video_reset); else n_pass++;
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL rmid_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  task automatic test_lock_timeout();
    logic [31:0] t;
    t = cyc;
    exp_wfr_q.push_back(t + 32'd2);
    pulse_trigger();
    run_until(t + 32'd2);  bus.pll_locked = 1'b0;
    run_until(t + 32'd5);  bus.busy = 1'b1;
    run_until(t + 32'd15); bus.busy = 1'b0;
    run_until(t + 32'd65550);
    n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL ltmo_state_wait: got %0d, want 4", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL ltmo_error_early: got %b, want 0", bus.error); else n_pass++;
    run_until(t + 32'd65551);
    n_checks++; if (bus.state_dbg !== 3'd6) $display("FAIL ltmo_state_error: got %0d, want 6", bus.state_dbg); else n_pass++;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL ltmo_error: got %b, want 1", bus.error); else n_pass++;
    n_checks++; if (bus.video_reset !== 1'b1) $display("FAIL ltmo_vr: got %b, want 1", bus.video_reset); else n_pass++;
    run_until(t + 32'd65560);
    n_checks++;
    if (exp_wfr_q.size() != 0 || exp_done_q.size() != 0) begin
      $display("FAIL ltmo_outstanding: wfr %0d done %0d left, want 0 0", exp_wfr_q.size(), exp_done_q.size());
      exp_wfr_q.delete(); exp_done_q.delete();
    end else n_pass++;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_done_edge();
    test_busy_never();
    test_reset_mid();
    test_lock_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
